// File: rtl/gs_ddram_bridge.sv
// Byte-wide General Sound memory port on the 64-bit DDRAM interface,
// with a single 8-byte line read cache and write-through on cached lines.
module gs_ddram_bridge #(
  parameter logic [28:0] BASE_WADDR = 29'h0600_0000,
  parameter int          AW         = 21
) (
  input  logic          DDRAM_CLK,
  input  logic          reset,
  input  logic          DDRAM_BUSY,
  output logic [7:0]    DDRAM_BURSTCNT,
  output logic [28:0]   DDRAM_ADDR,
  input  logic [63:0]   DDRAM_DOUT,
  input  logic          DDRAM_DOUT_READY,
  output logic          DDRAM_RD,
  output logic [63:0]   DDRAM_DIN,
  output logic [7:0]    DDRAM_BE,
  output logic          DDRAM_WE,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  input  logic          rd,
  input  logic          we,
  output logic          ready
);

  localparam int WW = AW - 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ
  } state_t;

  state_t        state_q;
  logic          old_rd_q;
  logic          old_we_q;
  logic [AW-1:0] addr_q;
  logic [7:0]    din_q;
  logic [63:0]   cache_q;
  logic [WW-1:0] tag_q;
  logic          valid_q;
  logic [7:0]    dout_q;
  logic          ready_q;
  logic          ddr_rd_q;
  logic          ddr_we_q;

  logic          rd_rise;
  logic          we_rise;
  logic          hit;
  logic [5:0]    in_lane;
  logic [5:0]    q_lane;

  assign rd_rise = rd & ~old_rd_q;
  assign we_rise = we & ~old_we_q;
  assign hit     = valid_q && (tag_q == addr[AW-1:3]);
  assign in_lane = {addr[2:0], 3'b000};
  assign q_lane  = {addr_q[2:0], 3'b000};

  always_ff @(posedge DDRAM_CLK or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      old_rd_q <= 1'b0;
      old_we_q <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      cache_q  <= '0;
      tag_q    <= '0;
      valid_q  <= 1'b0;
      dout_q   <= '0;
      ready_q  <= 1'b1;
      ddr_rd_q <= 1'b0;
      ddr_we_q <= 1'b0;
    end else begin
      old_rd_q <= rd;
      old_we_q <= we;
      case (state_q)
        ST_IDLE: begin
          if (we_rise) begin
            addr_q   <= addr;
            din_q    <= din;
            ddr_we_q <= 1'b1;
            ready_q  <= 1'b0;
            state_q  <= ST_WRITE;
            if (hit) begin
              cache_q[in_lane +: 8] <= din;
            end
          end else if (rd_rise) begin
            if (hit) begin
              dout_q <= cache_q[in_lane +: 8];
            end else begin
              addr_q   <= addr;
              ddr_rd_q <= 1'b1;
              ready_q  <= 1'b0;
              state_q  <= ST_READ;
            end
          end
        end
        ST_WRITE: begin
          if (!DDRAM_BUSY) begin
            ddr_we_q <= 1'b0;
            ready_q  <= 1'b1;
            state_q  <= ST_IDLE;
          end
        end
        ST_READ: begin
          if (!DDRAM_BUSY) begin
            ddr_rd_q <= 1'b0;
          end
          // Returned data implies the request was taken, so RD never survives into IDLE.
          if (DDRAM_DOUT_READY) begin
            ddr_rd_q <= 1'b0;
            cache_q  <= DDRAM_DOUT;
            tag_q    <= addr_q[AW-1:3];
            valid_q  <= 1'b1;
            dout_q   <= DDRAM_DOUT[q_lane +: 8];
            ready_q  <= 1'b1;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Request fields come only from latched registers, so they hold while BUSY is high.
  assign DDRAM_BURSTCNT = 8'd1;
  assign DDRAM_ADDR     = BASE_WADDR + {{(29 - WW){1'b0}}, addr_q[AW-1:3]};
  assign DDRAM_DIN      = {8{din_q}};
  assign DDRAM_BE       = 8'd1 << addr_q[2:0];
  assign DDRAM_RD       = ddr_rd_q;
  assign DDRAM_WE       = ddr_we_q;
  assign dout           = dout_q;
  assign ready          = ready_q;

endmodule

// File: tb/tb_gs_ddram_bridge.sv
// Scoreboard bench for gs_ddram_bridge with a small DDRAM responder model.
module tb_gs_ddram_bridge;

  localparam logic [28:0] BASE = 29'h0600_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        DDRAM_BUSY;
  logic [7:0]  DDRAM_BURSTCNT;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DOUT;
  logic        DDRAM_DOUT_READY;
  logic        DDRAM_RD;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE;
  logic        DDRAM_WE;
  logic [20:0] addr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        rd;
  logic        we;
  logic        ready;

  always #5 clk = ~clk;

  gs_ddram_bridge dut (
    .DDRAM_CLK        (clk),
    .reset            (rst),
    .DDRAM_BUSY       (DDRAM_BUSY),
    .DDRAM_BURSTCNT   (DDRAM_BURSTCNT),
    .DDRAM_ADDR       (DDRAM_ADDR),
    .DDRAM_DOUT       (DDRAM_DOUT),
    .DDRAM_DOUT_READY (DDRAM_DOUT_READY),
    .DDRAM_RD         (DDRAM_RD),
    .DDRAM_DIN        (DDRAM_DIN),
    .DDRAM_BE         (DDRAM_BE),
    .DDRAM_WE         (DDRAM_WE),
    .addr             (addr),
    .din              (din),
    .dout             (dout),
    .rd               (rd),
    .we               (we),
    .ready            (ready)
  );

  int total = 0;
  int bad   = 0;
  int rd_acc_cnt = 0;
  int wr_acc_cnt = 0;
  int both_cnt   = 0;
  int busy_cfg   = 0;
  int lat_cfg    = 1;

  logic [7:0]  exp_q[$];
  logic [7:0]  ref_mem [0:127];
  logic [63:0] ddr_mem [0:15];

  function automatic logic [63:0] init_word(input int w);
    if (w == 0) return 64'h8877665544332211;
    if (w == 1) return 64'hF0E0D0C0B0A09080;
    return {8{8'(8'h10 + w * 8'h11)}} ^ 64'h0706050403020100;
  endfunction

  // DDRAM responder: holds BUSY busy_cfg cycles per request, returns read data lat_cfg cycles after acceptance
  int          in_req = 0;
  int          busy_left = 0;
  int          rd_lat = 0;
  logic [3:0]  rd_word;
  logic [28:0] word;
  initial begin
    for (int w = 0; w < 16; w++) ddr_mem[w] = init_word(w);
    DDRAM_BUSY = 1'b0;
    DDRAM_DOUT_READY = 1'b0;
    DDRAM_DOUT = '0;
    rd_word = '0;
    forever begin
      @(posedge clk); #1;
      DDRAM_DOUT_READY = 1'b0;
      if (rst) begin
        in_req = 0;
        rd_lat = 0;
        DDRAM_BUSY = 1'b0;
      end else begin
        if (rd_lat > 0) begin
          rd_lat--;
          if (rd_lat == 0) begin
            DDRAM_DOUT_READY = 1'b1;
            DDRAM_DOUT = ddr_mem[rd_word];
          end
        end
        if ((DDRAM_RD || DDRAM_WE) && in_req == 0) begin
          in_req = 1;
          busy_left = busy_cfg;
        end
        if (in_req != 0) begin
          if (busy_left > 0) begin
            DDRAM_BUSY = 1'b1;
            busy_left--;
          end else begin
            DDRAM_BUSY = 1'b0;
            in_req = 0;
            word = DDRAM_ADDR - BASE;
            if (DDRAM_WE) begin
              wr_acc_cnt++;
              for (int b = 0; b < 8; b++)
                if (DDRAM_BE[b]) ddr_mem[word[3:0]][8*b +: 8] = DDRAM_DIN[8*b +: 8];
            end else begin
              rd_acc_cnt++;
              rd_word = word[3:0];
              if (lat_cfg == 0) begin
                DDRAM_DOUT_READY = 1'b1;
                DDRAM_DOUT = ddr_mem[word[3:0]];
              end else begin
                rd_lat = lat_cfg;
              end
            end
          end
        end else begin
          DDRAM_BUSY = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) if (DDRAM_RD === 1'b1 && DDRAM_WE === 1'b1) both_cnt++;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic rd_access(input logic [20:0] a, output logic [7:0] d, output int nreads,
                           output logic f_rd, output logic [28:0] f_addr, output logic f_ready,
                           output bit tmo);
    int n0;
    n0 = rd_acc_cnt;
    exp_q.push_back(ref_mem[a[6:0]]);
    addr = a;
    rd = 1'b1;
    @(posedge clk);
    @(negedge clk);
    f_rd = DDRAM_RD;
    f_addr = DDRAM_ADDR;
    f_ready = ready;
    tmo = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (ready === 1'b1) begin
        tmo = 1'b0;
        break;
      end
      @(negedge clk);
    end
    d = dout;
    nreads = rd_acc_cnt - n0;
    step();
    rd = 1'b0;
    step();
  endtask

  task automatic wr_access(input logic [20:0] a, input logic [7:0] v, input logic with_rd,
                           output logic f_we, output logic f_rd, output logic [28:0] f_addr,
                           output logic [7:0] f_be, output logic [63:0] f_din, output logic f_ready,
                           output int low, output int unstable, output int nwr, output int nrd,
                           output bit tmo);
    int w0;
    int r0;
    w0 = wr_acc_cnt;
    r0 = rd_acc_cnt;
    addr = a;
    din = v;
    we = 1'b1;
    if (with_rd) rd = 1'b1;
    @(posedge clk);
    @(negedge clk);
    f_we = DDRAM_WE;
    f_rd = DDRAM_RD;
    f_addr = DDRAM_ADDR;
    f_be = DDRAM_BE;
    f_din = DDRAM_DIN;
    f_ready = ready;
    low = 0;
    unstable = 0;
    tmo = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (ready === 1'b1) begin
        tmo = 1'b0;
        break;
      end
      low++;
      if (DDRAM_WE !== f_we || DDRAM_ADDR !== f_addr || DDRAM_BE !== f_be ||
          DDRAM_DIN !== f_din || DDRAM_RD !== 1'b0) unstable++;
      @(negedge clk);
    end
    nwr = wr_acc_cnt - w0;
    nrd = rd_acc_cnt - r0;
    step();
    we = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready); end
    total++; if (dout !== 8'h00) begin bad++; $display("FAIL reset_dout: got %h want 00", dout); end
    total++; if (DDRAM_RD !== 1'b0 || DDRAM_WE !== 1'b0) begin bad++; $display("FAIL reset_req: rd=%b we=%b want 0 0", DDRAM_RD, DDRAM_WE); end
    total++; if (DDRAM_BURSTCNT !== 8'd1) begin bad++; $display("FAIL burstcnt: got %h want 01", DDRAM_BURSTCNT); end
    step();
    rst = 1'b0;
    step();
    $display("reset: ready=%b dout=%h", ready, dout);
  endtask

  task automatic test_read_miss();
    logic [7:0] d, e; int n; logic frd, frdy; logic [28:0] fa; bit tmo;
    busy_cfg = 1; lat_cfg = 2;
    rd_access(21'h00005, d, n, frd, fa, frdy, tmo);
    e = exp_q.pop_front();
    total++; if (tmo) begin bad++; $display("FAIL miss_timeout: ready never returned"); end
    total++; if (frd !== 1'b1 || frdy !== 1'b0) begin bad++; $display("FAIL miss_start: rd=%b ready=%b want 1 0", frd, frdy); end
    total++; if (fa !== 29'h0600_0000) begin bad++; $display("FAIL miss_addr: got %h want 06000000", fa); end
    total++; if (n != 1) begin bad++; $display("FAIL miss_reads: got %0d want 1", n); end
    total++; if (d !== e) begin bad++; $display("FAIL miss_dout: got %h want %h", d, e); end
    $display("read miss addr=00005 dout=%h exp=%h reads=%0d", d, e, n);
  endtask

  task automatic test_read_hit();
    logic [7:0] d, e; int n; logic frd, frdy; logic [28:0] fa; bit tmo;
    rd_access(21'h00002, d, n, frd, fa, frdy, tmo);
    e = exp_q.pop_front();
    total++; if (frd !== 1'b0 || frdy !== 1'b1 || tmo) begin bad++; $display("FAIL hit_bus: rd=%b ready=%b want 0 1", frd, frdy); end
    total++; if (n != 0) begin bad++; $display("FAIL hit_reads: got %0d want 0", n); end
    total++; if (d !== e) begin bad++; $display("FAIL hit_dout: got %h want %h", d, e); end
    $display("read hit addr=00002 dout=%h exp=%h reads=%0d", d, e, n);
  endtask

  task automatic test_write_through();
    logic fwe, frd, frdy; logic [28:0] fa; logic [7:0] fbe, d, e; logic [63:0] fdin;
    int low, uns, nw, nr, n; bit tmo;
    wr_access(21'h00003, 8'hCC, 1'b0, fwe, frd, fa, fbe, fdin, frdy, low, uns, nw, nr, tmo);
    ref_mem[3] = 8'hCC;
    total++; if (nw != 1 || tmo) begin bad++; $display("FAIL wt_write: writes=%0d want 1", nw); end
    rd_access(21'h00003, d, n, frd, fa, frdy, tmo);
    e = exp_q.pop_front();
    total++; if (n != 0 || frdy !== 1'b1) begin bad++; $display("FAIL wt_hit: reads=%0d ready=%b want 0 1", n, frdy); end
    total++; if (d !== e) begin bad++; $display("FAIL wt_dout: got %h want %h", d, e); end
    $display("write-through addr=00003 dout=%h exp=%h reads=%0d", d, e, n);
  endtask

  task automatic test_write_busy();
    logic fwe, frd, frdy; logic [28:0] fa; logic [7:0] fbe, d, e; logic [63:0] fdin;
    int low, uns, nw, nr, n; bit tmo;
    busy_cfg = 3;
    wr_access(21'h0000A, 8'hAB, 1'b0, fwe, frd, fa, fbe, fdin, frdy, low, uns, nw, nr, tmo);
    ref_mem[10] = 8'hAB;
    busy_cfg = 0;
    total++; if (fwe !== 1'b1 || frdy !== 1'b0 || tmo) begin bad++; $display("FAIL wr_start: we=%b ready=%b want 1 0", fwe, frdy); end
    total++; if (fa !== 29'h0600_0001) begin bad++; $display("FAIL wr_addr: got %h want 06000001", fa); end
    total++; if (fbe !== 8'h04) begin bad++; $display("FAIL wr_be: got %h want 04", fbe); end
    total++; if (fdin !== {8{8'hAB}}) begin bad++; $display("FAIL wr_din: got %h want abababababababab", fdin); end
    total++; if (low != 4) begin bad++; $display("FAIL wr_busy_len: ready low %0d cycles want 4", low); end
    total++; if (uns != 0) begin bad++; $display("FAIL wr_hold: %0d unstable cycles want 0", uns); end
    rd_access(21'h0000A, d, n, frd, fa, frdy, tmo);
    e = exp_q.pop_front();
    total++; if (n != 1 || tmo) begin bad++; $display("FAIL wr_readback_reads: got %0d want 1", n); end
    total++; if (d !== e) begin bad++; $display("FAIL wr_readback: got %h want %h", d, e); end
    $display("write busy addr=0000A low=%0d readback=%h exp=%h", low, d, e);
  endtask

  task automatic test_back_to_back();
    logic fwe, frd, frdy; logic [28:0] fa; logic [7:0] fbe, d, e; logic [63:0] fdin;
    int low, uns, nw, nr, n, r0, w0, lo2; bit tmo;
    lat_cfg = 0;
    wr_access(21'h00010, 8'h5A, 1'b1, fwe, frd, fa, fbe, fdin, frdy, low, uns, nw, nr, tmo);
    ref_mem[16] = 8'h5A;
    total++; if (fwe !== 1'b1 || frd !== 1'b0 || nr != 0 || nw != 1) begin bad++; $display("FAIL both_rise: we=%b rd=%b reads=%0d writes=%0d want 1 0 0 1", fwe, frd, nr, nw); end
    r0 = rd_acc_cnt; w0 = wr_acc_cnt; lo2 = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ready !== 1'b1) lo2++;
    end
    total++; if (rd_acc_cnt != r0 || wr_acc_cnt != w0 || lo2 != 0) begin bad++; $display("FAIL rd_held: reads=%0d writes=%0d busy=%0d want 0 0 0", rd_acc_cnt - r0, wr_acc_cnt - w0, lo2); end
    step();
    rd = 1'b0;
    step();
    rd_access(21'h00010, d, n, frd, fa, frdy, tmo);
    e = exp_q.pop_front();
    total++; if (d !== e || n != 1 || tmo) begin bad++; $display("FAIL same_cycle_ready: dout=%h reads=%0d want %h 1", d, n, e); end
    lat_cfg = 1;
    $display("rd+we together addr=00010 readback=%h exp=%h", d, e);
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] d, e; int n; logic frd, frdy; logic [28:0] fa; bit tmo;
    busy_cfg = 10;
    addr = 21'h00020;
    rd = 1'b1;
    step(); step(); step();
    total++; if (DDRAM_RD !== 1'b1 || ready !== 1'b0) begin bad++; $display("FAIL pre_reset: rd=%b ready=%b want 1 0", DDRAM_RD, ready); end
    #1 rst = 1'b1;
    #1;
    total++; if (DDRAM_RD !== 1'b0 || ready !== 1'b1) begin bad++; $display("FAIL async_reset: rd=%b ready=%b want 0 1", DDRAM_RD, ready); end
    rd = 1'b0;
    step(); step();
    rst = 1'b0;
    busy_cfg = 0;
    step();
    rd_access(21'h00001, d, n, frd, fa, frdy, tmo);
    e = exp_q.pop_front();
    total++; if (n != 1 || frd !== 1'b1 || tmo) begin bad++; $display("FAIL post_reset_miss: reads=%0d rd=%b want 1 1", n, frd); end
    total++; if (d !== e) begin bad++; $display("FAIL post_reset_dout: got %h want %h", d, e); end
    $display("reset mid-read, then addr=00001 dout=%h exp=%h reads=%0d", d, e, n);
  endtask

  initial begin
    rst = 1'b1; rd = 1'b0; we = 1'b0; addr = '0; din = '0;
    for (int w = 0; w < 16; w++) begin
      logic [63:0] iw;
      iw = init_word(w);
      for (int b = 0; b < 8; b++) ref_mem[w*8 + b] = iw[8*b +: 8];
    end
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_through();
    test_write_busy();
    test_back_to_back();
    test_reset_mid_read();
    total++; if (both_cnt != 0) begin bad++; $display("FAIL rd_we_overlap: %0d cycles want 0", both_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
